// File: rtl/t64_mem_pkg.sv
// t64_mem_pkg: shared width encodings, sequencer states and access-size helpers for mem_seq.
package t64_mem_pkg;
    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_DBL  = 2'b11;

    typedef enum logic [1:0] {IDLE, BEAT, WB, FLT} state_t;

    // A byte access still costs one full 16-bit beat.
    function automatic logic [2:0] beats(input logic [1:0] w);
        return (w == W_DBL) ? 3'd4 : (w == W_WORD) ? 3'd2 : 3'd1;
    endfunction

    function automatic logic misaligned(input logic [1:0] w, input logic [2:0] a);
        return (w == W_HALF) ? a[0] : (w == W_WORD) ? |a[1:0] : (w == W_DBL) ? |a : 1'b0;
    endfunction
endpackage

// File: rtl/mem_seq_load_extend.sv
// load_extend: picks the loaded bytes out of the assembly register and extends them to 64 bits.
// MEM_SEQ_SIGNEXT_EN selects sign extension; the default build zero-extends.
module load_extend
    import t64_mem_pkg::*;
(
    input  logic [63:0] i_asm,
    input  logic [1:0]  i_width,
    input  logic        i_addr0,
    output logic [63:0] o_data
);
    logic [7:0] w_byte;
    logic       w_sign;

    // A byte load fetched the whole halfword; the odd address picks the upper lane.
    assign w_byte = i_addr0 ? i_asm[15:8] : i_asm[7:0];

`ifdef MEM_SEQ_SIGNEXT_EN
    assign w_sign = (i_width == W_BYTE) ? w_byte[7] : (i_width == W_HALF) ? i_asm[15] : i_asm[31];
`else
    assign w_sign = 1'b0;
`endif

    assign o_data = (i_width == W_BYTE) ? {{56{w_sign}}, w_byte} :
                    (i_width == W_HALF) ? {{48{w_sign}}, i_asm[15:0]} :
                    (i_width == W_WORD) ? {{32{w_sign}}, i_asm[31:0]} : i_asm;
endmodule

// File: rtl/mem_seq.sv
// mem_seq: sequences 64-bit loads/stores over a 16-bit request/ack bus and writes loads back to the regfile.
// Define MEM_SEQ_SIGNEXT_EN to sign-extend narrow loads (handled in load_extend).
module mem_seq
    import t64_mem_pkg::*;
#(
    parameter int BUS_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             we,
    input  logic [1:0]       width,
    input  logic [63:0]      addr,
    input  logic [63:0]      wdata,
    input  logic [3:0]       dst,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [63:0]      rf_din,
    output logic             rf_wr,
    output logic [3:0]       rf_wrsel,
    output logic [1:0]       rf_width,
    output logic [63:0]      bus_addr,
    output logic [BUS_W-1:0] bus_dout,
    input  logic [BUS_W-1:0] bus_din,
    output logic [1:0]       bus_be,
    output logic             bus_we,
    output logic             bus_req,
    input  logic             bus_ack
);
    state_t      r_state, w_next;
    logic [1:0]  r_beat;
    logic        r_we;
    logic [1:0]  r_width;
    logic [63:0] r_addr, r_wdata, r_asm;
    logic [3:0]  r_dst;
    logic        w_beat, w_last, w_misal;
    logic [63:0] w_ext;

    assign w_beat  = r_state == BEAT;
    assign w_last  = {1'b0, r_beat} == beats(r_width) - 3'd1;
    assign w_misal = misaligned(width, addr[2:0]);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? (w_misal ? FLT : BEAT) : IDLE;
            BEAT:    w_next = (bus_ack && w_last) ? (r_we ? IDLE : WB) : BEAT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat  <= '0;
            r_we    <= 1'b0;
            r_width <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dst   <= '0;
            r_asm   <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_beat  <= '0;
                r_we    <= we;
                r_width <= width;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_dst   <= dst;
                r_asm   <= '0;
            end
            if (w_beat && bus_ack) begin
                r_asm[{r_beat, 4'b0000} +: 16] <= bus_din;
                r_beat <= r_beat + 2'd1;
            end
        end
    end

    load_extend u_ext (
        .i_asm   (r_asm),
        .i_width (r_width),
        .i_addr0 (r_addr[0]),
        .o_data  (w_ext)
    );

    // Bus and regfile fields are gated to their active state so they read 0 out of reset.
    assign busy     = r_state != IDLE;
    assign bus_req  = w_beat;
    assign bus_we   = w_beat & r_we;
    assign bus_addr = w_beat ? {r_addr[63:1], 1'b0} + {61'd0, r_beat, 1'b0} : '0;
    assign bus_be   = !w_beat ? 2'b00 : (r_width != W_BYTE) ? 2'b11 : r_addr[0] ? 2'b10 : 2'b01;
    assign bus_dout = !w_beat ? '0 : (r_width == W_BYTE) ? {2{r_wdata[7:0]}} : r_wdata[{r_beat, 4'b0000} +: 16];
    assign done     = (r_state == WB) || (w_beat && r_we && bus_ack && w_last);
    assign fault    = r_state == FLT;
    assign rf_wr    = r_state == WB;
    assign rf_din   = rf_wr ? w_ext : '0;
    assign rf_wrsel = rf_wr ? r_dst : '0;
    assign rf_width = rf_wr ? r_width : '0;
endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: transaction-level model of mem_seq backed by a byte-addressed bench memory acting as the bus slave.
module tb_mem_seq;
    typedef struct packed {
        logic [63:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, start, we, busy, done, fault, rf_wr, bus_we, bus_req, bus_ack;
    logic [1:0]  width, rf_width, bus_be;
    logic [63:0] addr, wdata, rf_din, bus_addr;
    logic [3:0]  dst, rf_wrsel;
    logic [15:0] bus_dout, bus_din;

    always #5 clk = ~clk;

    mem_seq dut (
        .clk(clk), .reset(reset), .start(start), .we(we), .width(width), .addr(addr),
        .wdata(wdata), .dst(dst), .busy(busy), .done(done), .fault(fault), .rf_din(rf_din),
        .rf_wr(rf_wr), .rf_wrsel(rf_wrsel), .rf_width(rf_width), .bus_addr(bus_addr),
        .bus_dout(bus_dout), .bus_din(bus_din), .bus_be(bus_be), .bus_we(bus_we),
        .bus_req(bus_req), .bus_ack(bus_ack)
    );

    int n_chk = 0, n_err = 0, cyc_n = 0;
    int n_done = 0, n_rfwr = 0, n_fault = 0, n_req = 0, acc_cyc = 0, done_cyc = 0;
    int ack_mode = 0, dly = 0;
    logic [63:0] last_rf = '0;
    logic [63:0] log_a[$];
    logic [15:0] log_d[$];
    logic [15:0] mem[logic [63:0]];

    int          m_phase = 0;
    beat_t       m_q[$];
    logic        m_we = 1'b0, m_rst = 1'b0;
    logic [63:0] m_val = '0;
    logic [3:0]  m_dst = '0;
    logic [1:0]  m_width = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic logic [15:0] rd_half(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : (a[15:0] ^ a[47:32] ^ 16'h5A3C);
    endfunction

    // Expected load result straight from memory bytes, little-endian, then extended.
    function automatic logic [63:0] load_val(input logic [63:0] a, input logic [1:0] w);
        int nb;
        logic [63:0] v, ba;
        logic [15:0] h;
        nb = 1 << w;
        v = '0;
        for (int i = 0; i < nb; i++) begin
            ba = a + 64'(i);
            h = rd_half({ba[63:1], 1'b0});
            v = v | (64'(ba[0] ? h[15:8] : h[7:0]) << (8 * i));
        end
`ifdef MEM_SEQ_SIGNEXT_EN
        if (nb < 8 && v[8 * nb - 1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
`endif
        return v;
    endfunction

    function automatic logic mis(input logic [63:0] a, input logic [1:0] w);
        return (a % (64'd1 << w)) != 64'd0;
    endfunction

    always @(negedge clk) begin
        beat_t b;
        int nb;
        logic [15:0] h;
        cyc_n++;
        if (m_rst) begin
            chk("rst_rf_din", rf_din, 64'd0);
            chk("rst_rf_wrsel", 64'(rf_wrsel), 64'd0);
            chk("rst_rf_width", 64'(rf_width), 64'd0);
            chk("rst_bus_addr", bus_addr, 64'd0);
            chk("rst_bus_dout", 64'(bus_dout), 64'd0);
            chk("rst_bus_be", 64'(bus_be), 64'd0);
        end
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("bus_req", 64'(bus_req), 64'(m_phase == 1));
        chk("fault", 64'(fault), 64'(m_phase == 3));
        chk("rf_wr", 64'(rf_wr), 64'(m_phase == 2));
        chk("done", 64'(done), 64'(m_phase == 2 || (m_phase == 1 && m_we && bus_ack && m_q.size() == 1)));
        if (m_phase == 1) begin
            b = m_q[0];
            chk("bus_addr", bus_addr, b.a);
            chk("bus_be", 64'(bus_be), 64'(b.be));
            chk("bus_we", 64'(bus_we), 64'(m_we));
            if (m_we) chk("bus_dout", 64'(bus_dout), 64'(b.d));
        end else begin
            chk("bus_we_idle", 64'(bus_we), 64'd0);
        end
        if (m_phase == 2) begin
            chk("rf_din", rf_din, m_val);
            chk("rf_wrsel", 64'(rf_wrsel), 64'(m_dst));
            chk("rf_width", 64'(rf_width), 64'(m_width));
        end
        if (done) begin n_done++; done_cyc = cyc_n; end
        if (rf_wr) begin n_rfwr++; last_rf = rf_din; end
        if (fault) n_fault++;
        if (bus_req) n_req++;
        if (bus_req && bus_ack) begin
            log_a.push_back(bus_addr);
            log_d.push_back(bus_dout);
            if (bus_we) begin
                h = rd_half(bus_addr);
                if (bus_be[0]) h[7:0] = bus_dout[7:0];
                if (bus_be[1]) h[15:8] = bus_dout[15:8];
                mem[bus_addr] = h;
            end
        end
        m_rst = reset;
        if (reset) begin
            m_phase = 0;
            m_q.delete();
        end else if (m_phase == 0) begin
            if (start) begin
                acc_cyc = cyc_n;
                m_we = we; m_dst = dst; m_width = width;
                if (mis(addr, width)) m_phase = 3;
                else begin
                    nb = 1 << width;
                    for (int k = 0; k < (nb < 2 ? 1 : nb / 2); k++) begin
                        b.a = {addr[63:1], 1'b0} + 64'(2 * k);
                        b.be = (nb > 1) ? 2'b11 : addr[0] ? 2'b10 : 2'b01;
                        b.d = (nb == 1) ? {2{wdata[7:0]}} : wdata[16 * k +: 16];
                        m_q.push_back(b);
                    end
                    m_val = load_val(addr, width);
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (bus_ack) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_phase = m_we ? 0 : 2;
            end
        end else begin
            m_phase = 0;
        end
    end

    task automatic drive(input logic s, input logic w, input logic [1:0] wd, input logic [63:0] a,
                         input logic [63:0] wdt, input logic [3:0] d, input logic r);
        @(posedge clk);
        #1;
        start = s; we = w; width = wd; addr = a; wdata = wdt; dst = d; reset = r;
        bus_din = rd_half(bus_addr);
        if (ack_mode == 0) bus_ack = 1'b1;
        else if (ack_mode == 1) bus_ack = 1'($urandom_range(0, 1));
        else if (bus_req) begin
            bus_ack = dly == 2;
            dly = (dly == 2) ? 0 : dly + 1;
        end else bus_ack = 1'b0;
    endtask

    task automatic idle1();
        drive(1'b0, 1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            idle1();
            k++;
        end while (m_phase != 0 && k < 200);
        n_chk++;
        if (m_phase != 0) begin
            n_err++;
            $display("FAIL timeout: transaction still open after %0d cycles, required idle", k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_done, b_rf, b_req, b_flt;
        logic [63:0] exp_b, a;
        reset = 1'b1; start = 1'b0; we = 1'b0; width = '0; addr = '0; wdata = '0; dst = '0;
        bus_din = '0; bus_ack = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b1);
        drive(1'b0, 1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b1);
        idle1();

        mem[64'h100] = 16'h5678; mem[64'h102] = 16'h1234; mem[64'h200] = 16'h80AA;
        ack_mode = 0; log_a.delete(); log_d.delete(); b_rf = n_rfwr;
        drive(1'b1, 1'b0, 2'b10, 64'h100, 64'd0, 4'd5, 1'b0);
        wait_idle();
        chk("wld_addr0", log_a[0], 64'h100);
        chk("wld_addr1", log_a[1], 64'h102);
        chk("wld_data", last_rf, 64'h12345678);
        chk("wld_latency", 64'(done_cyc - acc_cyc), 64'd3);
        chk("wld_rfwr", 64'(n_rfwr - b_rf), 64'd1);

`ifdef MEM_SEQ_SIGNEXT_EN
        exp_b = 64'hFFFF_FFFF_FFFF_FF80;
`else
        exp_b = 64'h80;
`endif
        drive(1'b1, 1'b0, 2'b00, 64'h201, 64'd0, 4'd3, 1'b0);
        wait_idle();
        chk("bld_data", last_rf, exp_b);

        ack_mode = 2; dly = 0; log_d.delete(); b_done = n_done; b_rf = n_rfwr;
        drive(1'b1, 1'b1, 2'b11, 64'h40, 64'h1122334455667788, 4'd0, 1'b0);
        wait_idle();
        chk("dst_beat0", 64'(log_d[0]), 64'h7788);
        chk("dst_beat1", 64'(log_d[1]), 64'h5566);
        chk("dst_beat2", 64'(log_d[2]), 64'h3344);
        chk("dst_beat3", 64'(log_d[3]), 64'h1122);
        chk("dst_done", 64'(n_done - b_done), 64'd1);
        chk("dst_no_rfwr", 64'(n_rfwr - b_rf), 64'd0);
        ack_mode = 1;
        drive(1'b1, 1'b0, 2'b11, 64'h40, 64'd0, 4'd9, 1'b0);
        wait_idle();
        chk("dld_readback", last_rf, 64'h1122334455667788);

        b_req = n_req; b_flt = n_fault;
        drive(1'b1, 1'b0, 2'b01, 64'h3, 64'd0, 4'd1, 1'b0);
        idle1();
        idle1();
        chk("flt_busy", 64'(busy), 64'd0);
        chk("flt_count", 64'(n_fault - b_flt), 64'd1);
        chk("flt_no_req", 64'(n_req - b_req), 64'd0);

        ack_mode = 0; b_rf = n_rfwr;
        drive(1'b1, 1'b0, 2'b11, 64'h80, 64'd0, 4'd2, 1'b0);
        idle1();
        idle1();
        drive(1'b0, 1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b1);
        chk("rst_at_beat2", bus_addr, 64'h84);
        idle1();
        chk("rst_req", 64'(bus_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        idle1();
        chk("rst_no_rfwr", 64'(n_rfwr - b_rf), 64'd0);
        drive(1'b1, 1'b0, 2'b00, 64'h201, 64'd0, 4'd4, 1'b0);
        wait_idle();
        chk("rst_then_bld", last_rf, exp_b);

        ack_mode = 2; dly = 0; b_done = n_done;
        drive(1'b1, 1'b0, 2'b10, 64'h300, 64'd0, 4'd1, 1'b0);
        idle1();
        drive(1'b1, 1'b1, 2'b00, 64'h500, 64'hAB, 4'd2, 1'b0);
        wait_idle();
        idle1();
        idle1();
        chk("busy_start_done", 64'(n_done - b_done), 64'd1);

        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin ack_mode = $urandom_range(0, 2); dly = 0; end
            case ($urandom_range(0, 2))
                0: a = {$urandom, $urandom};
                1: a = 64'h1000 + 64'($urandom_range(0, 63));
                default: a = 64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(0, 63));
            endcase
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                  {$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 199) == 0));
        end
        ack_mode = 0;
        wait_idle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
